vram_arbiter: RTL
=================

# vram_arbiter

Initiator-side scheduler that owns the request interface of the SDRAM memory controller (`MEM_CONTROLLER`). It arbitrates three VDP clients onto that single port: the renderer (16/32-bit reads), the command engine (8/16/32-bit reads and writes) and the CPU port (8-bit reads and writes). It also generates periodic auto-refresh, issues one-cycle strobes only when the controller is idle, and returns read data to the originating client with a valid pulse.

## Interface
- `REFRESH_INTERVAL`, default 405: cycles between refresh requests (7.5 µs at 54 MHz).
- `clk` in 1: logic clock, same as the memory controller.
- `resetn` in 1: asynchronous, active-low reset.
- `rnd_req` in 1, `rnd_addr` in 23, `rnd_size` in 2: renderer read request. Held stable until ack.
- `rnd_ack` out 1, `rnd_valid` out 1, `rnd_data` out 32: accept pulse, read-data pulse, read data.
- `cmd_req` in 1, `cmd_wr` in 1, `cmd_addr` in 23, `cmd_size` in 2, `cmd_din` in 32: command engine request.
- `cmd_ack` out 1, `cmd_valid` out 1, `cmd_data` out 32: command engine response.
- `cpu_req` in 1, `cpu_wr` in 1, `cpu_addr` in 23, `cpu_din` in 8: CPU request.
- `cpu_ack` out 1, `cpu_valid` out 1, `cpu_data` out 8: CPU response.
- `mem_read`, `mem_write`, `mem_refresh` out 1 each: one-cycle strobes to the controller.
- `mem_addr` out 23, `mem_rd_size` out 2, `mem_wr_size` out 2: address and width encoding to the controller.
- `mem_din8` out 8, `mem_din16` out 16, `mem_din32` out 32: write data to the controller.
- `mem_dout32` in 32, `mem_busy` in 1, `mem_enabled` in 1: controller outputs.
- `err_protocol` out 1: sticky flag, set when the controller did not go busy after a strobe.
- `err_refresh_late` out 1: sticky flag, set when a refresh interval expired while the previous refresh was still pending.

## Operation
- Size encoding: 00 = 8 bit, 01 = 16 bit, 10 = 32 bit, 11 is treated as 16 bit.
- All outputs are registered. Reset value of every output is 0.
- States:
  - INIT → IDLE when `mem_enabled`=1 and `mem_busy`=0.
  - IDLE → LAUNCH when a grant is made.
  - LAUNCH → WAIT always, next cycle.
  - WAIT → IDLE on the first sample of `mem_busy`=0.
- Grant priority in IDLE, sampled with `mem_busy`=0:
  1. refresh_pending
  2. rnd_req
  3. cmd_req and cpu_req, resolved by a round-robin bit. The bit toggles to favour the other port after each cmd or cpu grant.
- On grant:
  - Exactly one of `mem_read`/`mem_write`/`mem_refresh` pulses for one cycle.
  - The matching `*_ack` pulses in the same cycle.
  - `mem_addr`, the sizes and `mem_din*` are loaded, and held stable until the next grant.
- Renderer requests are always reads. `mem_rd_size` = `rnd_size`.
- 8-bit reads (CPU always; cmd with size 00) are issued as 16-bit reads. The byte is selected on return by the request's addr[0]: 1 selects bits [15:8], 0 selects bits [7:0]. The cmd result is zero-extended.
- Writes:
  - CPU write: `mem_wr_size`=00, `mem_din8` = `cpu_din`.
  - cmd write: `mem_din8` = `cmd_din[7:0]`, `mem_din16` = `cmd_din[15:0]`, `mem_din32` = `cmd_din`, `mem_wr_size` = `cmd_size`.
- Read return: in WAIT, on the first `mem_busy`=0 sample, `mem_dout32` is captured. The owner's `*_data` is updated and `*_valid` pulses for one cycle. `*_data` holds until that owner's next read completes. Writes and refresh produce no valid pulse.
- Refresh counter:
  - Held at `REFRESH_INTERVAL`-1 while in INIT.
  - Otherwise decrements every cycle; at 0 it reloads and sets refresh_pending.
  - refresh_pending clears when the refresh is granted.
  - If the counter hits 0 while refresh_pending is already 1, `err_refresh_late` is set.
- LAUNCH checks that `mem_busy`=1. If not, `err_protocol` is set and the FSM still proceeds to WAIT, which exits at once.
- Reset mid-operation: everything returns to INIT asynchronously. Pending data is dropped and no valid pulse is emitted.

## Timing
- Grant/strobe in cycle T.
- Controller busy T+1..T+4, observed low at T+5.
- Read data: `*_valid` high in T+6.
- FSM back in IDLE at T+6; the earliest next strobe is T+7. Maximum rate is one access per 7 cycles.
- Refresh is granted within one access time of being pending: at most 7 cycles after the counter hits 0.
- A request asserted in cycle T while IDLE can be acked at T+1 at the earliest.
- Simultaneous requests: `rnd_req` and `cmd_req` in the same IDLE cycle → renderer first; cmd is acked at the next grant.
- Refresh and render coinciding → refresh first.

## Test plan
- Reset, then hold `mem_busy`=1 for 20 cycles and release → no strobe before `mem_busy` falls; first grant is possible the cycle after entering IDLE.
- Renderer read of addr 0x000100, size 10, model returns 0xDEADBEEF → `mem_read` pulse with `rnd_ack`; `rnd_valid` exactly 6 cycles later; `rnd_data`=0xDEADBEEF.
- CPU read of addr 0x000003, model returns 0x0000A55A → `mem_rd_size`=01; `cpu_data`=0xA5. Repeat with addr 0x000002 → `cpu_data`=0x5A.
- `cmd_req` and `cpu_req` held continuously, both writes → grants alternate cmd, cpu, cmd, cpu. `mem_wr_size` is 10 for cmd size 10 and 00 for CPU; `mem_din8` = `cpu_din` = 0x3C.
- `REFRESH_INTERVAL`=16 with constant `rnd_req` → `mem_refresh` wins the next IDLE after each expiry and `err_refresh_late` stays 0. Then stall `mem_busy`=1 for 40 cycles → `err_refresh_late`=1.
- Model never raises `mem_busy` after a strobe → `err_protocol`=1 two cycles later. Assert `resetn`=0 during WAIT → all outputs 0 immediately and no `*_valid` after release.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// vram_arbiter: schedules renderer, command-engine and CPU accesses plus periodic
// auto-refresh onto the single SDRAM controller request port, routing read data back.
module vram_arbiter #(
  parameter int REFRESH_INTERVAL = 405
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rnd_req,
  input  logic [22:0] rnd_addr,
  input  logic [1:0]  rnd_size,
  output logic        rnd_ack,
  output logic        rnd_valid,
  output logic [31:0] rnd_data,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [22:0] cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_din,
  output logic        cmd_ack,
  output logic        cmd_valid,
  output logic [31:0] cmd_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic        cpu_valid,
  output logic [7:0]  cpu_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_rd_size,
  output logic [1:0]  mem_wr_size,
  output logic [7:0]  mem_din8,
  output logic [15:0] mem_din16,
  output logic [31:0] mem_din32,
  input  logic [31:0] mem_dout32,
  input  logic        mem_busy,
  input  logic        mem_enabled,
  output logic        err_protocol,
  output logic        err_refresh_late
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_LAUNCH = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_RND  = 2'd1;
  localparam logic [1:0] OWN_CMD  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  localparam logic [1:0] SZ_8  = 2'b00;
  localparam logic [1:0] SZ_16 = 2'b01;

  localparam int            CW     = $clog2(REFRESH_INTERVAL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] rfcnt_q, rfcnt_d;
  logic          rfpend_q, rfpend_d;
  logic          rr_q, rr_d;
  logic [1:0]    owner_q, owner_d;
  logic          narrow_q, narrow_d;
  logic          bsel_q, bsel_d;
  logic          chk_q, chk_d;

  logic          rnd_ack_q, rnd_ack_d, rnd_valid_q, rnd_valid_d;
  logic [31:0]   rnd_data_q, rnd_data_d;
  logic          cmd_ack_q, cmd_ack_d, cmd_valid_q, cmd_valid_d;
  logic [31:0]   cmd_data_q, cmd_data_d;
  logic          cpu_ack_q, cpu_ack_d, cpu_valid_q, cpu_valid_d;
  logic [7:0]    cpu_data_q, cpu_data_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic          mem_refresh_q, mem_refresh_d;
  logic [22:0]   mem_addr_q, mem_addr_d;
  logic [1:0]    mem_rd_size_q, mem_rd_size_d, mem_wr_size_q, mem_wr_size_d;
  logic [7:0]    mem_din8_q, mem_din8_d;
  logic [15:0]   mem_din16_q, mem_din16_d;
  logic [31:0]   mem_din32_q, mem_din32_d;
  logic          err_proto_q, err_proto_d, err_late_q, err_late_d;

  logic          can_grant, gnt_ref, gnt_rnd, gnt_cc, gnt_cmd, gnt_cpu;
  logic [7:0]    ret_byte;

  // Size code 11 is an alias of the 16-bit access.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_16 : s;
  endfunction

  assign can_grant = (state_q == S_IDLE) && !mem_busy;
  assign gnt_ref   = can_grant && rfpend_q;
  assign gnt_rnd   = can_grant && !rfpend_q && rnd_req;
  assign gnt_cc    = can_grant && !rfpend_q && !rnd_req;
  assign gnt_cmd   = gnt_cc && cmd_req && (!cpu_req || !rr_q);
  assign gnt_cpu   = gnt_cc && cpu_req && (!cmd_req || rr_q);
  assign ret_byte  = bsel_q ? mem_dout32[15:8] : mem_dout32[7:0];

  always_comb begin
    state_d       = state_q;
    rfcnt_d       = rfcnt_q;
    rfpend_d      = rfpend_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    narrow_d      = narrow_q;
    bsel_d        = bsel_q;
    chk_d         = (state_q == S_LAUNCH);
    rnd_ack_d     = 1'b0;
    rnd_valid_d   = 1'b0;
    rnd_data_d    = rnd_data_q;
    cmd_ack_d     = 1'b0;
    cmd_valid_d   = 1'b0;
    cmd_data_d    = cmd_data_q;
    cpu_ack_d     = 1'b0;
    cpu_valid_d   = 1'b0;
    cpu_data_d    = cpu_data_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_refresh_d = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_rd_size_d = mem_rd_size_q;
    mem_wr_size_d = mem_wr_size_q;
    mem_din8_d    = mem_din8_q;
    mem_din16_d   = mem_din16_q;
    mem_din32_d   = mem_din32_q;
    err_proto_d   = err_proto_q;
    err_late_d    = err_late_q;

    case (state_q)
      S_INIT: begin
        if (mem_enabled && !mem_busy) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (gnt_ref || gnt_rnd || gnt_cmd || gnt_cpu) state_d = S_LAUNCH;
        if (gnt_ref) begin
          mem_refresh_d = 1'b1;
          rfpend_d      = 1'b0;
          owner_d       = OWN_NONE;
        end else if (gnt_rnd) begin
          mem_read_d    = 1'b1;
          rnd_ack_d     = 1'b1;
          mem_addr_d    = rnd_addr;
          mem_rd_size_d = norm_size(rnd_size);
          owner_d       = OWN_RND;
          narrow_d      = 1'b0;
        end else if (gnt_cmd) begin
          cmd_ack_d  = 1'b1;
          mem_addr_d = cmd_addr;
          rr_d       = 1'b1;
          if (cmd_wr) begin
            mem_write_d   = 1'b1;
            mem_wr_size_d = norm_size(cmd_size);
            mem_din8_d    = cmd_din[7:0];
            mem_din16_d   = cmd_din[15:0];
            mem_din32_d   = cmd_din;
            owner_d       = OWN_NONE;
          end else begin
            // Byte reads go out as 16-bit reads; the byte lane is picked on return.
            mem_read_d    = 1'b1;
            mem_rd_size_d = (cmd_size == SZ_8) ? SZ_16 : norm_size(cmd_size);
            owner_d       = OWN_CMD;
            narrow_d      = (cmd_size == SZ_8);
            bsel_d        = cmd_addr[0];
          end
        end else if (gnt_cpu) begin
          cpu_ack_d  = 1'b1;
          mem_addr_d = cpu_addr;
          rr_d       = 1'b0;
          if (cpu_wr) begin
            mem_write_d   = 1'b1;
            mem_wr_size_d = SZ_8;
            mem_din8_d    = cpu_din;
            owner_d       = OWN_NONE;
          end else begin
            mem_read_d    = 1'b1;
            mem_rd_size_d = SZ_16;
            owner_d       = OWN_CPU;
            narrow_d      = 1'b1;
            bsel_d        = cpu_addr[0];
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      default: begin
        // The controller only raises busy the cycle after the strobe, so the
        // launch check is made on the first WAIT cycle.
        if (!mem_busy) begin
          state_d = S_IDLE;
          if (chk_q) err_proto_d = 1'b1;
          case (owner_q)
            OWN_RND: begin
              rnd_valid_d = 1'b1;
              rnd_data_d  = mem_dout32;
            end
            OWN_CMD: begin
              cmd_valid_d = 1'b1;
              cmd_data_d  = narrow_q ? {24'h0, ret_byte} : mem_dout32;
            end
            OWN_CPU: begin
              cpu_valid_d = 1'b1;
              cpu_data_d  = ret_byte;
            end
            default: ;
          endcase
          owner_d = OWN_NONE;
        end
      end
    endcase

    // Expiry overrides the grant-side clear of the pending flag.
    if (state_q == S_INIT) begin
      rfcnt_d = RELOAD;
    end else if (rfcnt_q == '0) begin
      rfcnt_d  = RELOAD;
      rfpend_d = 1'b1;
      if (rfpend_q && !gnt_ref) err_late_d = 1'b1;
    end else begin
      rfcnt_d = rfcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_INIT;
      rfcnt_q       <= RELOAD;
      rfpend_q      <= 1'b0;
      rr_q          <= 1'b0;
      owner_q       <= OWN_NONE;
      narrow_q      <= 1'b0;
      bsel_q        <= 1'b0;
      chk_q         <= 1'b0;
      rnd_ack_q     <= 1'b0;
      rnd_valid_q   <= 1'b0;
      rnd_data_q    <= '0;
      cmd_ack_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_data_q    <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_valid_q   <= 1'b0;
      cpu_data_q    <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_rd_size_q <= '0;
      mem_wr_size_q <= '0;
      mem_din8_q    <= '0;
      mem_din16_q   <= '0;
      mem_din32_q   <= '0;
      err_proto_q   <= 1'b0;
      err_late_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rfcnt_q       <= rfcnt_d;
      rfpend_q      <= rfpend_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      narrow_q      <= narrow_d;
      bsel_q        <= bsel_d;
      chk_q         <= chk_d;
      rnd_ack_q     <= rnd_ack_d;
      rnd_valid_q   <= rnd_valid_d;
      rnd_data_q    <= rnd_data_d;
      cmd_ack_q     <= cmd_ack_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_data_q    <= cmd_data_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_valid_q   <= cpu_valid_d;
      cpu_data_q    <= cpu_data_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_refresh_q <= mem_refresh_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_size_q <= mem_rd_size_d;
      mem_wr_size_q <= mem_wr_size_d;
      mem_din8_q    <= mem_din8_d;
      mem_din16_q   <= mem_din16_d;
      mem_din32_q   <= mem_din32_d;
      err_proto_q   <= err_proto_d;
      err_late_q    <= err_late_d;
    end
  end

  assign rnd_ack          = rnd_ack_q;
  assign rnd_valid        = rnd_valid_q;
  assign rnd_data         = rnd_data_q;
  assign cmd_ack          = cmd_ack_q;
  assign cmd_valid        = cmd_valid_q;
  assign cmd_data         = cmd_data_q;
  assign cpu_ack          = cpu_ack_q;
  assign cpu_valid        = cpu_valid_q;
  assign cpu_data         = cpu_data_q;
  assign mem_read         = mem_read_q;
  assign mem_write        = mem_write_q;
  assign mem_refresh      = mem_refresh_q;
  assign mem_addr         = mem_addr_q;
  assign mem_rd_size      = mem_rd_size_q;
  assign mem_wr_size      = mem_wr_size_q;
  assign mem_din8         = mem_din8_q;
  assign mem_din16        = mem_din16_q;
  assign mem_din32        = mem_din32_q;
  assign err_protocol     = err_proto_q;
  assign err_refresh_late = err_late_q;

endmodule
`default_nettype wire
